// File: rtl/uwire_rx_deser_if.sv
// Bus-side handshake bundle for the 93xx read-data deserialiser.
// master = bus-decode logic, slave = deserialiser.
interface uwire_rx_deser_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ack;
  logic              overrun;
  logic              dummy_err;

  modport master (
    output start, rd_ack,
    input  busy, rd_data, rd_valid, overrun, dummy_err
  );

  modport slave (
    input  start, rd_ack,
    output busy, rd_data, rd_valid, overrun, dummy_err
  );
endinterface

// File: rtl/uwire_rx_deser.sv
// 93xx serial-EEPROM read-data deserialiser: generates SK, samples DO at
// the end of each SK high phase, assembles an MSB-first word and hands it
// to the bus side with a valid/ack handshake. All outputs are registered.
module uwire_rx_deser #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int DUMMY_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sdi,
  output logic sclk,
  uwire_rx_deser_if.slave bus
);
  localparam int NB = DUMMY_BIT + DATA_W;
  localparam int CW = $clog2(NB + 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(NB - 1);

  typedef enum logic [1:0] {IDLE, SK_LO, SK_HI} state_t;

  state_t            state;
  logic [7:0]        div;
  logic [CW-1:0]     bit_cnt;
  // Only DATA_W-1 bits need storage: the last bit comes straight from sdi.
  logic [DATA_W-2:0] shift;
  logic [DATA_W-1:0] word_nxt;
  logic              is_dummy;

  assign word_nxt = {shift, sdi};
  assign is_dummy = (DUMMY_BIT != 0) && (bit_cnt == '0);

  // Sequencer, shifter and bus-side handshake in one registered block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      div           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      sclk          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.dummy_err <= 1'b0;
    end else begin
      // Consumer ack; a completion on this same edge overrides it below.
      if (bus.rd_ack && bus.rd_valid) bus.rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= SK_LO;
            bus.busy      <= 1'b1;
            div           <= '0;
            bit_cnt       <= '0;
            bus.overrun   <= 1'b0;
            bus.dummy_err <= 1'b0;
          end
        end
        SK_LO: begin
          if (div == DIV_LAST) begin
            div   <= '0;
            sclk  <= 1'b1;
            state <= SK_HI;
          end else begin
            div <= div + 8'd1;
          end
        end
        SK_HI: begin
          if (div == DIV_LAST) begin
            div     <= '0;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + CW'(1);
            // The leading dummy bit is checked but never enters the word.
            if (is_dummy) begin
              if (sdi) bus.dummy_err <= 1'b1;
            end else begin
              shift <= word_nxt[DATA_W-2:0];
            end
            if (bit_cnt == BIT_LAST) begin
              state        <= IDLE;
              bus.busy     <= 1'b0;
              bus.rd_data  <= word_nxt;
              bus.rd_valid <= 1'b1;
              if (bus.rd_valid && !bus.rd_ack) bus.overrun <= 1'b1;
            end else begin
              state <= SK_LO;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uwire_rx_deser.sv
// Bench for uwire_rx_deser: default x16/dummy instance plus an x8,
// CLK_DIV=1, no-dummy instance. Device models shift data out on SK rise.
`timescale 1ns/1ps
module tb_uwire_rx_deser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdi0 = 1'b0, sdi8 = 1'b0;
  logic sclk0, sclk8;

  uwire_rx_deser_if #(.DATA_W(16)) bus0();
  uwire_rx_deser_if #(.DATA_W(8))  bus8();

  uwire_rx_deser u_dut0 (.clk(clk), .rst(rst), .sdi(sdi0), .sclk(sclk0), .bus(bus0));
  uwire_rx_deser #(.DATA_W(8), .CLK_DIV(1), .DUMMY_BIT(0))
    u_dut8 (.clk(clk), .rst(rst), .sdi(sdi8), .sclk(sclk8), .bus(bus8));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device model and SK monitor, default instance.
  logic [16:0] dev0_sr;
  int  sk0_cnt;
  time sk0_last, p_min, p_max, hi_min, hi_max;
  always @(posedge sclk0) begin
    sk0_cnt++;
    if (sk0_last != 0) begin
      if ($time - sk0_last < p_min) p_min = $time - sk0_last;
      if ($time - sk0_last > p_max) p_max = $time - sk0_last;
    end
    sk0_last = $time;
    sdi0 = dev0_sr[16];
    dev0_sr = dev0_sr << 1;
  end
  always @(negedge sclk0) begin
    if (sk0_last != 0 && !rst) begin
      if ($time - sk0_last < hi_min) hi_min = $time - sk0_last;
      if ($time - sk0_last > hi_max) hi_max = $time - sk0_last;
    end
  end

  // Device model and SK monitor, x8 instance.
  logic [7:0] dev8_sr;
  int sk8_cnt;
  always @(posedge sclk8) begin
    sk8_cnt++;
    sdi8 = dev8_sr[7];
    dev8_sr = dev8_sr << 1;
  end

  // Scoreboard: expected words queued at start, popped at completion.
  logic [15:0] exp_q[$];
  bit exp_valid = 0, exp_overrun = 0;

  task automatic xfer0(input logic dmy, input logic [15:0] w, input bit ack_done);
    int c;
    bit done;
    dev0_sr = {dmy, w};
    sdi0 = 1'b0;
    sk0_cnt = 0; sk0_last = 0;
    p_min = 1000000; p_max = 0; hi_min = 1000000; hi_max = 0;
    exp_q.push_back(w);
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    chk("acc_busy", bus0.busy, 1);
    chk("acc_dummy_err_clr", bus0.dummy_err, 0);
    chk("acc_overrun_clr", bus0.overrun, 0);
    c = 0; done = 0;
    while (!done && c < 2000) begin
      bus0.rd_ack = (ack_done && c == 135);
      @(posedge clk); c++; #1;
      if (!bus0.busy) done = 1;
    end
    bus0.rd_ack = 1'b0;
    chk("done_in_time", done, 1);
    chk("latency", c, 136);
    chk("sk_rises", sk0_cnt, 17);
    chk("sk_period_min", 32'(p_min), 80);
    chk("sk_period_max", 32'(p_max), 80);
    chk("sk_high_min", 32'(hi_min), 40);
    chk("sk_high_max", 32'(hi_max), 40);
    chk("sclk_low_idle", sclk0, 0);
    exp_overrun = exp_valid && !ack_done;
    exp_valid = 1;
    chk("rd_valid", bus0.rd_valid, exp_valid);
    chk("overrun", bus0.overrun, exp_overrun);
    chk("dummy_err", bus0.dummy_err, dmy);
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("rd_data", bus0.rd_data, exp_q.pop_front());
  endtask

  task automatic ack0();
    @(negedge clk); bus0.rd_ack = 1'b1;
    @(negedge clk); bus0.rd_ack = 1'b0;
    exp_valid = 0;
    chk("ack_rd_valid", bus0.rd_valid, 0);
    chk("ack_overrun_kept", bus0.overrun, exp_overrun);
  endtask

  initial begin
    int c, lat, tog;
    logic prev;
    bus0.start = 0; bus0.rd_ack = 0;
    bus8.start = 0; bus8.rd_ack = 0;
    dev0_sr = '0; dev8_sr = '0;
    sk0_cnt = 0; sk8_cnt = 0; sk0_last = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sclk", sclk0, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_rd_data", bus0.rd_data, 0);
    chk("rst_rd_valid", bus0.rd_valid, 0);
    chk("rst_overrun", bus0.overrun, 0);
    chk("rst_dummy_err", bus0.dummy_err, 0);

    // Basic read with good dummy bit, then accept it.
    xfer0(1'b0, 16'hA5C3, 0);
    ack0();
    // Dummy bit high: flagged, and cleared by the next accepted start.
    xfer0(1'b1, 16'hFFFF, 0);
    ack0();
    // Unacked word overwritten: overrun set, survives the ack.
    xfer0(1'b0, 16'h1234, 0);
    xfer0(1'b0, 16'h5678, 0);
    ack0();
    // Ack on the completion edge: new word valid, no overrun.
    xfer0(1'b0, 16'h9ABC, 0);
    xfer0(1'b0, 16'hDEF0, 1);

    // Async reset during the 9th SK high phase, with a word still pending.
    dev0_sr = {1'b0, 16'h3C3C}; sk0_cnt = 0; sk0_last = 0;
    @(negedge clk); bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    c = 0;
    while (sk0_cnt < 9 && c < 2000) begin @(posedge clk); #1; c++; end
    chk("reach_9th_rise", sk0_cnt, 9);
    #11 rst = 1'b1;
    #1;
    chk("arst_sclk", sclk0, 0);
    chk("arst_busy", bus0.busy, 0);
    chk("arst_rd_valid", bus0.rd_valid, 0);
    chk("arst_rd_data", bus0.rd_data, 0);
    @(negedge clk); rst = 1'b0;
    exp_valid = 0; exp_overrun = 0;
    xfer0(1'b0, 16'h2468, 0);

    // x8, CLK_DIV=1, no dummy; extra start pulses while busy.
    dev8_sr = 8'h81; sk8_cnt = 0;
    @(negedge clk); bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    c = 0; lat = 0; tog = 0;
    while (c < 24) begin
      bus8.start = ((c >= 3 && c <= 6) || c == 10);
      prev = sclk8;
      @(posedge clk); c++; #1;
      if (sclk8 != prev) tog++;
      if (!bus8.busy && lat == 0) lat = c;
    end
    bus8.start = 1'b0;
    chk("x8_latency", lat, 16);
    chk("x8_toggles", tog, 16);
    chk("x8_sk_rises", sk8_cnt, 8);
    chk("x8_rd_data", bus8.rd_data, 8'h81);
    chk("x8_rd_valid", bus8.rd_valid, 1);
    chk("x8_idle", bus8.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
